// File: rtl/dmem_pkg.sv
// Shared types and defaults for the wait-state data-memory responder.
package dmem_pkg;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_WAIT  = 2;
  localparam int IDX_W     = $clog2(DEF_DEPTH);

  // IDLE / WAIT / RESP; prefixed so they never collide with the WAIT parameter
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/dmem_if.sv
// Requester <-> responder data-bus signals.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;

  modport master (output req, we, a, wd, input rd, ready, err);
  modport slave  (input req, we, a, wd, output rd, ready, err);
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, never cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = IDX_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wd;

  assign rd = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-bus responder with WAIT inserted cycles per access,
// alignment/range checking and a one-cycle ready/err completion pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT  = DEF_WAIT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t      state, nstate;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_a, cap_wd;
  logic        cur_we;
  logic [31:0] cur_a, cur_wd;
  logic        ok, go_resp, mem_we, err_q;
  logic [31:0] mem_rd, rd_q;

  // In IDLE the access may complete on this very edge (WAIT=0), so look at the bus
  assign cur_we = (state == S_IDLE) ? bus.we : cap_we;
  assign cur_a  = (state == S_IDLE) ? bus.a  : cap_a;
  assign cur_wd = (state == S_IDLE) ? bus.wd : cap_wd;

  assign ok      = (cur_a[1:0] == 2'b00) && ({2'b00, cur_a[31:2]} < 32'(DEPTH));
  assign go_resp = !reset && (nstate == S_RESP);
  assign mem_we  = go_resp && cur_we && ok;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (cur_a[AW+1:2]),
    .wd   (cur_wd),
    .rd   (mem_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (bus.req) nstate = (WAIT == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) nstate = S_RESP;
      S_RESP:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      cap_we <= 1'b0;
      cap_a  <= '0;
      cap_wd <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.req) begin
        cap_we <= bus.we;
        cap_a  <= bus.a;
        cap_wd <= bus.wd;
        cnt    <= (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Response data is frozen from the array as it stands when entering RESP
      if (go_resp) begin
        rd_q  <= (ok && !cur_we) ? mem_rd : '0;
        err_q <= !ok;
      end
    end
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.err   = 1'b0;
    bus.rd    = '0;
    if (state == S_RESP) begin
      bus.ready = 1'b1;
      bus.err   = err_q;
      bus.rd    = rd_q;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT=0 and WAIT=2 instances against a word-array model.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_d = 2'b11;
  logic [1:0]  req_d = 2'b00;
  logic        we_d  = 1'b0;
  logic [31:0] a_d   = '0;
  logic [31:0] wd_d  = '0;
  logic [1:0]  rdy, erv;
  logic [1:0][31:0] rdv;
  int checks = 0;
  int passed = 0;
  logic [31:0] model [2][64];

  dmem_if bus0 ();
  dmem_if bus1 ();

  assign bus0.req = req_d[0];
  assign bus0.we  = we_d;
  assign bus0.a   = a_d;
  assign bus0.wd  = wd_d;
  assign bus1.req = req_d[1];
  assign bus1.we  = we_d;
  assign bus1.a   = a_d;
  assign bus1.wd  = wd_d;
  assign rdy    = {bus1.ready, bus0.ready};
  assign erv    = {bus1.err, bus0.err};
  assign rdv[0] = bus0.rd;
  assign rdv[1] = bus1.rd;

  dmem_responder #(.WAIT(0), .DEPTH(64)) dut0 (.clk(clk), .reset(rst_d[0]), .bus(bus0));
  dmem_responder #(.WAIT(2), .DEPTH(64)) dut1 (.clk(clk), .reset(rst_d[1]), .bus(bus1));

  function automatic int wv(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  function automatic bit valid_addr(input logic [31:0] addr);
    return (addr % 4 == 0) && (addr / 4 < 64);
  endfunction

  // One request on instance s; lat = cycles from the sampling edge to ready, -1 on timeout
  task automatic txn(input int s, input logic w, input logic [31:0] addr, input logic [31:0] data,
                     output int lat, output logic [31:0] r, output logic e, output int early);
    @(negedge clk);
    req_d[s] = 1'b1; we_d = w; a_d = addr; wd_d = data;
    lat = -1; r = '0; e = 1'b0; early = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (rdy[s]) begin lat = k; r = rdv[s]; e = erv[s]; break; end
      if (erv[s] !== 1'b0 || rdv[s] !== 32'd0) early++;
    end
    req_d[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst_d = 2'b11; req_d = 2'b00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({rdy[s], erv[s], rdv[s]} !== 34'd0)
        $display("FAIL reset_outputs[%0d]: got ready=%b err=%b rd=%h exp all zero", s, rdy[s], erv[s], rdv[s]);
      else passed++;
    end
    rst_d = 2'b00;
  endtask

  task automatic test_latency();
    int lat, early; logic [31:0] r; logic e;
    txn(1, 1'b1, 32'd100, 32'd7, lat, r, e, early);
    model[1][25] = 32'd7;
    checks++; if (lat !== 3) $display("FAIL lat_write: got %0d exp 3", lat); else passed++;
    checks++; if (e !== 1'b0 || early !== 0) $display("FAIL write_err: err=%b early=%0d exp 0/0", e, early); else passed++;
    txn(1, 1'b0, 32'd100, 32'd0, lat, r, e, early);
    checks++; if (lat !== 3) $display("FAIL lat_read: got %0d exp 3", lat); else passed++;
    checks++; if (r !== 32'd7 || e !== 1'b0) $display("FAIL raw_read: got rd=%h err=%b exp 7/0", r, e); else passed++;
  endtask

  task automatic test_bad_addr();
    int lat, early; logic [31:0] r; logic e;
    txn(1, 1'b1, 32'd0, 32'h1234_5678, lat, r, e, early);
    model[1][0] = 32'h1234_5678;
    checks++; if (e !== 1'b0) $display("FAIL word0_write: err=%b exp 0", e); else passed++;
    txn(1, 1'b0, 32'h66, 32'd0, lat, r, e, early);
    checks++;
    if (lat !== 3 || e !== 1'b1 || r !== 32'd0)
      $display("FAIL misaligned: got lat=%0d err=%b rd=%h exp 3/1/0", lat, e, r);
    else passed++;
    txn(1, 1'b1, 32'h100, 32'hFFFF_FFFF, lat, r, e, early);
    checks++; if (e !== 1'b1 || lat !== 3) $display("FAIL out_of_range: got err=%b lat=%0d exp 1/3", e, lat); else passed++;
    txn(1, 1'b0, 32'd0, 32'd0, lat, r, e, early);
    checks++; if (r !== model[1][0] || e !== 1'b0) $display("FAIL word0_intact: got %h exp %h", r, model[1][0]); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, early, n; logic [31:0] r; logic e;
    txn(1, 1'b1, 32'd96, 32'd3, lat, r, e, early);
    model[1][24] = 32'd3;
    // reset while waiting
    @(negedge clk); req_d[1] = 1'b1; we_d = 1'b1; a_d = 32'd96; wd_d = 32'd5;
    @(negedge clk); n = int'(rdy[1]); rst_d[1] = 1'b1; req_d[1] = 1'b0;
    @(negedge clk); n += int'(rdy[1]); rst_d[1] = 1'b0;
    repeat (5) begin @(negedge clk); n += int'(rdy[1]); end
    checks++; if (n !== 0) $display("FAIL reset_in_wait: got %0d ready pulses exp 0", n); else passed++;
    // reset on the edge that would commit
    @(negedge clk); req_d[1] = 1'b1; we_d = 1'b1; a_d = 32'd96; wd_d = 32'd9;
    @(negedge clk); n = int'(rdy[1]);
    @(negedge clk); n += int'(rdy[1]); rst_d[1] = 1'b1; req_d[1] = 1'b0;
    @(negedge clk); n += int'(rdy[1]); rst_d[1] = 1'b0;
    repeat (5) begin @(negedge clk); n += int'(rdy[1]); end
    checks++; if (n !== 0) $display("FAIL reset_at_commit: got %0d ready pulses exp 0", n); else passed++;
    // reset and req together
    @(negedge clk); rst_d[1] = 1'b1; req_d[1] = 1'b1; we_d = 1'b1; a_d = 32'd96; wd_d = 32'd11;
    @(negedge clk); rst_d[1] = 1'b0; req_d[1] = 1'b0; n = 0;
    repeat (6) begin @(negedge clk); n += int'(rdy[1]); end
    checks++; if (n !== 0) $display("FAIL reset_with_req: got %0d ready pulses exp 0", n); else passed++;
    txn(1, 1'b0, 32'd96, 32'd0, lat, r, e, early);
    checks++; if (r !== 32'd3 || e !== 1'b0) $display("FAIL word96_kept: got %h exp 3", r); else passed++;
  endtask

  task automatic test_held_req(input int s);
    int period, bad, n;
    period = wv(s) + 2; bad = 0; n = 0;
    @(negedge clk); req_d[s] = 1'b1; we_d = 1'b0; a_d = 32'd0;
    for (int c = 1; c <= 4 * period; c++) begin
      @(negedge clk);
      if (rdy[s] !== ((c % period) == period - 1)) bad++;
      if (rdy[s] === 1'b1) n++;
    end
    req_d[s] = 1'b0;
    checks++; if (bad !== 0) $display("FAIL held_req_timing[%0d]: got %0d misplaced cycles exp 0", s, bad); else passed++;
    checks++; if (n !== 4) $display("FAIL held_req_count[%0d]: got %0d pulses exp 4", s, n); else passed++;
  endtask

  task automatic test_wait0();
    int lat, early; logic [31:0] r; logic e;
    txn(0, 1'b1, 32'd4, 32'hDEAD_BEEF, lat, r, e, early);
    model[0][1] = 32'hDEAD_BEEF;
    checks++; if (lat !== 1 || e !== 1'b0) $display("FAIL w0_write: got lat=%0d err=%b exp 1/0", lat, e); else passed++;
    txn(0, 1'b0, 32'd4, 32'd0, lat, r, e, early);
    checks++; if (lat !== 1) $display("FAIL w0_read_lat: got %0d exp 1", lat); else passed++;
    checks++; if (r !== 32'hDEAD_BEEF) $display("FAIL w0_read_data: got %h exp deadbeef", r); else passed++;
  endtask

  task automatic test_stability();
    int lat, early; logic [31:0] r; logic e;
    txn(1, 1'b1, 32'd12, 32'h0BAD_0BAD, lat, r, e, early);
    model[1][3] = 32'h0BAD_0BAD;
    @(negedge clk); req_d[1] = 1'b1; we_d = 1'b1; a_d = 32'd8; wd_d = 32'hA5A5_A5A5;
    @(negedge clk); we_d = 1'b0; a_d = 32'd12; wd_d = 32'h1111_1111;
    lat = 1;
    while (rdy[1] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    e = erv[1];
    req_d[1] = 1'b0;
    model[1][2] = 32'hA5A5_A5A5;
    checks++; if (lat !== 3 || e !== 1'b0) $display("FAIL stable_resp: got lat=%0d err=%b exp 3/0", lat, e); else passed++;
    txn(1, 1'b0, 32'd8, 32'd0, lat, r, e, early);
    checks++; if (r !== 32'hA5A5_A5A5) $display("FAIL stable_word8: got %h exp a5a5a5a5", r); else passed++;
    txn(1, 1'b0, 32'd12, 32'd0, lat, r, e, early);
    checks++; if (r !== 32'h0BAD_0BAD) $display("FAIL stable_word12: got %h exp 0bad0bad", r); else passed++;
  endtask

  task automatic test_random(input int s);
    int lat, early, idx, bad;
    logic [31:0] r, addr, data, exp_r;
    logic e, w, ok;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      data = $urandom;
      txn(s, 1'b1, 32'(i * 4), data, lat, r, e, early);
      model[s][i] = data;
      if (lat !== wv(s) + 1 || e !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL preload[%0d]: got %0d bad writes exp 0", s, bad); else passed++;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    addr = 32'($urandom_range(0, 63) * 4);
        2:       addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        3:       addr = 32'($urandom_range(64, 2000) * 4);
        default: addr = $urandom | 32'h8000_0000;
      endcase
      w = 1'($urandom_range(0, 1));
      data = $urandom;
      ok = valid_addr(addr);
      idx = ok ? int'(addr / 4) : 0;
      exp_r = (ok && !w) ? model[s][idx] : 32'd0;
      txn(s, w, addr, data, lat, r, e, early);
      if (ok && w) model[s][idx] = data;
      checks++; if (lat !== wv(s) + 1) $display("FAIL rnd_lat[%0d] a=%h: got %0d exp %0d", s, addr, lat, wv(s) + 1); else passed++;
      checks++; if (e !== !ok) $display("FAIL rnd_err[%0d] a=%h: got %b exp %b", s, addr, e, !ok); else passed++;
      checks++; if (r !== exp_r) $display("FAIL rnd_rd[%0d] a=%h we=%b: got %h exp %h", s, addr, w, r, exp_r); else passed++;
      checks++; if (early !== 0) $display("FAIL rnd_idle_out[%0d]: got %0d nonzero cycles exp 0", s, early); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bad_addr();
    test_reset_mid();
    test_held_req(1);
    test_held_req(0);
    test_wait0();
    test_stability();
    test_random(1);
    test_random(0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT, default 2: wait cycles inserted before each response; legal range 0..15.
REQ-002 SHALL have parameter DEPTH, default 64: number of 32-bit words of storage.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  requester asserts to start a data-bus transaction.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port a  input  32  byte address; sampled with req.
REQ-008 SHALL have port wd  input  32  write data; sampled with req.
REQ-009 SHALL have port rd  output  32  read data; valid only while ready=1.
REQ-010 SHALL have port ready  output  1  one-cycle pulse marking transaction completion.
REQ-011 SHALL have port err  output  1  qualifies ready: transaction rejected.

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-013 IDLE: on req=1 at a clock edge, SHALL capture we, a, wd into internal registers and go to WAIT, or go to RESP directly when WAIT=0.
REQ-014 WAIT: SHALL count WAIT cycles with a 4-bit counter loaded at capture, then go to RESP.
REQ-015 RESP: SHALL drive ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-016 Latency: req sampled at edge N -> ready high during cycle N+WAIT+1.
REQ-017 Throughput: at most one transaction per WAIT+2 cycles; req sampled only in IDLE.
REQ-018 The requester holds req, we, a, wd stable until ready. Input changes after capture SHALL be ignored.
REQ-019 If req is still high in the RESP cycle, SHALL NOT treat it as a new request. A new request is captured only from IDLE on the following edge.
REQ-020 Valid access: a[1:0]==0 and a[31:2] < DEPTH. Word index = a[31:2].
REQ-021 Invalid access (misaligned or out of range) SHALL assert err=1 together with ready, perform no write, and drive rd=0.
REQ-022 Valid write SHALL commit wd to storage on the edge entering RESP. During RESP, ready=1, err=0, rd=0.
REQ-023 Valid read SHALL present storage[index] on rd during RESP, sampled from the array as of entering RESP.
REQ-024 Outside RESP, ready, err and rd SHALL all be 0.
REQ-025 A read immediately following a write to the same word SHALL return the newly written value.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, clear the counter and captured registers, and drive ready=0, err=0, rd=0 from the next cycle.
REQ-027 Reset during WAIT SHALL abandon the transaction; a pending write SHALL NOT commit.
REQ-028 Reset coinciding with the commit edge SHALL take priority: no write.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 reset and req high together SHALL leave the FSM in IDLE with no capture.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state enum type (IDLE/WAIT/RESP), the default DEPTH and WAIT constants, and the word-index width.
REQ-032 Storage SHALL be a sub-module dmem_array: DEPTH x 32, synchronous write, combinational read, write-enable driven by the FSM.
REQ-033 FSM, counter, capture registers and address check SHALL live in dmem_responder.

Verification
REQ-034 Latency: WAIT=2; req=1, we=1, a=100, wd=7 at edge 0 -> ready=1, err=0 in cycle 3. Then a read of a=100 -> rd=7 with ready, 3 cycles after its req.
REQ-035 Misaligned and out-of-range: read a=0x66 -> ready=1, err=1, rd=0. Write a=0x100 (DEPTH=64) -> err=1, and a later read of a=0 is unchanged.
REQ-036 Reset mid-write: preload word 96 = 3; write a=96, wd=5; reset during WAIT -> ready never asserted; later read a=96 returns 3.
REQ-037 Held req: req held high through RESP -> exactly one ready per WAIT+2 cycles, with no ready in the cycle after RESP.
REQ-038 WAIT=0: write a=4, wd=0xDEADBEEF at edge 0 -> ready in cycle 1. Read a=4 -> rd=0xDEADBEEF one cycle after its req.
REQ-039 Stability: change a and wd during WAIT -> the response reflects the captured values only.
